// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch/hazard controller.
package fetch_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    // Pipeline-register controls produced each cycle.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect
    import fetch_ctrl_pkg::*;
(
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             lu_c
);

    assign lu_c = ex_memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch sequencer against a req/ack instruction memory plus hazard stall/flush control.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module fetch_hazard_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCSrc,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             fetch_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    fetch_state_e      state, state_nxt;
    logic              discard_pend, discard_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              lu_c;
    logic              active_c;
    logic              accept_c;
    logic              drop_c;
    logic              err_set_c;
    pipe_ctrl_t        ctrl_c;

    hazard_detect u_hazard_detect (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .lu_c       (lu_c)
    );

    // Next state, discard tracking, wait counting and pipeline controls.
    always_comb begin
        state_nxt    = state;
        discard_nxt  = discard_pend;
        wait_cnt_nxt = '0;
        accept_c     = 1'b0;
        drop_c       = 1'b0;
        active_c     = (state != S_BOOT);

        case (state)
            S_BOOT: state_nxt = S_REQ;
            S_REQ: begin
                state_nxt    = S_WAIT;
                wait_cnt_nxt = WAIT_W'(1);
                if (PCSrc) discard_nxt = 1'b1;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    if (discard_pend || PCSrc) begin
                        drop_c      = 1'b1;
                        discard_nxt = 1'b0;
                        state_nxt   = S_REQ;
                    end else if (lu_c) begin
                        state_nxt = S_HOLD;
                    end else begin
                        accept_c  = 1'b1;
                        state_nxt = S_REQ;
                    end
                end else begin
                    wait_cnt_nxt = (wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt + WAIT_W'(1);
                    if (PCSrc) discard_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (PCSrc) begin
                    state_nxt = S_REQ;
                end else if (!lu_c) begin
                    accept_c  = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_BOOT;
        endcase

        err_set_c = (state_nxt == S_WAIT) && (wait_cnt_nxt >= WAIT_LIMIT);

        ctrl_c.pc_write    = active_c && (PCSrc || accept_c);
        ctrl_c.ifid_write  = accept_c;
        ctrl_c.ifid_flush  = (active_c && PCSrc) || drop_c;
        ctrl_c.idex_flush  = active_c && (PCSrc || lu_c);
        ctrl_c.exmem_flush = active_c && PCSrc;
    end

    assign pc_write    = ctrl_c.pc_write;
    assign ifid_write  = ctrl_c.ifid_write;
    assign ifid_flush  = ctrl_c.ifid_flush;
    assign idex_flush  = ctrl_c.idex_flush;
    assign exmem_flush = ctrl_c.exmem_flush;

    // State, request strobe and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_BOOT;
            discard_pend <= 1'b0;
            wait_cnt     <= '0;
            imem_req     <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            state        <= state_nxt;
            discard_pend <= discard_nxt;
            wait_cnt     <= wait_cnt_nxt;
            imem_req     <= (state_nxt == S_REQ);
            fetch_err    <= fetch_err || err_set_c;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating stall and redirect counters, idle while booting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (active_c) begin
            if (!ctrl_c.pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
            if (PCSrc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Randomized scoreboard bench for fetch_hazard_ctrl against a fetch-transaction model.
module tb_fetch_hazard_ctrl;

    localparam int unsigned MAX_WAIT = 16;
    localparam int unsigned CNT_W    = 32;

    logic             clk = 1'b1;
    logic             rst_n = 1'b0;
    logic             PCSrc = 1'b0;
    logic             ex_memread = 1'b0;
    logic [4:0]       ex_rt = '0;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic             imem_ack = 1'b0;
    logic             imem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, fetch_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    fetch_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCSrc        (PCSrc),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .imem_ack     (imem_ack),
        .imem_req     (imem_req),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .fetch_err    (fetch_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             imem_req;
        logic             pc_write;
        logic             ifid_write;
        logic             ifid_flush;
        logic             idex_flush;
        logic             exmem_flush;
        logic             fetch_err;
        logic [CNT_W-1:0] stall_cycles;
        logic [CNT_W-1:0] flush_count;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    // Fetch-transaction view: booting, issuing a request, awaiting the word, or holding it.
    bit               booting = 1'b1;
    bit               issuing = 1'b0;
    bit               awaiting = 1'b0;
    bit               holding = 1'b0;
    bit               stale = 1'b0;
    bit               err = 1'b0;
    int               waited = 0;
    logic [CNT_W-1:0] n_stall = '0;
    logic [CNT_W-1:0] n_flush = '0;

    function automatic bit load_use();
        return ex_memread && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        bit   lu;
        bit   acc;
        e  = '0;
        lu = load_use();
        if (!rst_n) return e;
`ifdef HAZARD_STATS_EN
        e.stall_cycles = n_stall;
        e.flush_count  = n_flush;
`endif
        e.fetch_err = err || (awaiting && (waited + 1 >= int'(MAX_WAIT)));
        if (booting) return e;
        acc = (awaiting && imem_ack && !stale && !lu && !PCSrc) || (holding && !lu && !PCSrc);
        e.imem_req    = issuing;
        e.pc_write    = PCSrc || acc;
        e.ifid_write  = acc;
        e.idex_flush  = PCSrc || lu;
        e.exmem_flush = PCSrc;
        e.ifid_flush  = PCSrc || (awaiting && imem_ack && stale);
        return e;
    endfunction

    task automatic advance(input exp_t e);
        bit lu;
        lu = load_use();
        if (!rst_n) begin
            booting = 1'b1; issuing = 1'b0; awaiting = 1'b0; holding = 1'b0;
            stale = 1'b0; err = 1'b0; waited = 0; n_stall = '0; n_flush = '0;
        end else if (booting) begin
            booting = 1'b0;
            issuing = 1'b1;
        end else begin
            if (!e.pc_write) n_stall = n_stall + 1;
            if (PCSrc) n_flush = n_flush + 1;
            if (issuing) begin
                issuing = 1'b0; awaiting = 1'b1; waited = 0;
                if (PCSrc) stale = 1'b1;
            end else if (awaiting) begin
                waited = waited + 1;
                if (waited >= int'(MAX_WAIT)) err = 1'b1;
                if (imem_ack) begin
                    awaiting = 1'b0;
                    if (stale || PCSrc) begin
                        stale = 1'b0; issuing = 1'b1;
                    end else if (lu) begin
                        holding = 1'b1;
                    end else begin
                        issuing = 1'b1;
                    end
                end else if (PCSrc) begin
                    stale = 1'b1;
                end
            end else if (holding) begin
                if (PCSrc || !lu) begin
                    holding = 1'b0; issuing = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'd10;
        endcase
    endfunction

    // Inputs change 1 time unit after the rising edge; expected outputs queued for the monitor.
    task automatic cycle();
        exp_t e;
        e = predict();
        sb_q.push_back(e);
        @(posedge clk);
        advance(e);
        #1;
    endtask

    task automatic run(input int n, input int pc_pct, input int ack_pct, input int lu_pct);
        for (int i = 0; i < n; i++) begin
            PCSrc      = ($urandom_range(0, 99) < pc_pct);
            imem_ack   = ($urandom_range(0, 99) < ack_pct);
            ex_memread = ($urandom_range(0, 99) < lu_pct);
            ex_rt      = pick_reg();
            id_rs      = pick_reg();
            id_rt      = pick_reg();
            cycle();
        end
    endtask

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("imem_req",     CNT_W'(imem_req),    CNT_W'(e.imem_req));
            check("pc_write",     CNT_W'(pc_write),    CNT_W'(e.pc_write));
            check("ifid_write",   CNT_W'(ifid_write),  CNT_W'(e.ifid_write));
            check("ifid_flush",   CNT_W'(ifid_flush),  CNT_W'(e.ifid_flush));
            check("idex_flush",   CNT_W'(idex_flush),  CNT_W'(e.idex_flush));
            check("exmem_flush",  CNT_W'(exmem_flush), CNT_W'(e.exmem_flush));
            check("fetch_err",    CNT_W'(fetch_err),   CNT_W'(e.fetch_err));
            check("stall_cycles", stall_cycles,        e.stall_cycles);
            check("flush_count",  flush_count,         e.flush_count);
        end
    end

    initial begin
        #1;
        rst_n = 1'b0;
        run(3, 20, 50, 30);
        rst_n = 1'b1;
        run(40, 0, 100, 0);
        run(300, 10, 50, 30);
        run(25, 0, 0, 0);
        run(30, 10, 60, 20);
        run(4, 0, 0, 0);
        rst_n = 1'b0;
        run(2, 30, 100, 30);
        rst_n = 1'b1;
        run(300, 15, 40, 30);
        run(40, 30, 50, 0);
        run(30, 5, 100, 60);
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
